// File: rtl/bist_pkg.sv
// Shared BIST definitions: run-controller states and the LFSR step used by both the TPG and the MISR.
// TPG_ZERO_PATTERN_EN is applied by the callers, which pass it in as the zero_en argument.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CUT_RST = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned LFSR_MAX_W = 32;

  // Mask covering the low 'width' bits of a LFSR_MAX_W-bit word
  function automatic logic [LFSR_MAX_W-1:0] width_mask(input int unsigned width);
    if (width >= LFSR_MAX_W) return '1;
    return (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
  endfunction

  // An all-zero seed would lock a plain LFSR, so it loads 1 instead
  function automatic logic [LFSR_MAX_W-1:0] seed_fix(input logic [LFSR_MAX_W-1:0] seed,
                                                     input int unsigned width);
    logic [LFSR_MAX_W-1:0] w_s;
    w_s = seed & width_mask(width);
    if (w_s == '0) return LFSR_MAX_W'(1);
    return w_s;
  endfunction

  // Fibonacci step: shift left, feedback from the tapped stages into bit 0.
  // zero_en turns it into a de Bruijn counter that also visits the all-zero state.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] s,
                                                      input logic [LFSR_MAX_W-1:0] poly,
                                                      input int unsigned width,
                                                      input logic zero_en);
    logic [LFSR_MAX_W-1:0] w_mask;
    logic [LFSR_MAX_W-1:0] w_low;
    logic [LFSR_MAX_W-1:0] w_nxt;
    logic                  w_fb;
    w_mask = width_mask(width);
    w_low  = width_mask(width - 1);
    w_fb   = ^(s & poly & w_mask);
    if (zero_en && ((s & w_low) == '0)) w_fb = ~w_fb;
    w_nxt = ((s << 1) | LFSR_MAX_W'(w_fb)) & w_mask;
    if (!zero_en && ((s & w_mask) == '0)) w_nxt = LFSR_MAX_W'(1);
    return w_nxt;
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Loadable pattern LFSR: load wins over advance; reset and load both restore the (fixed-up) seed.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int unsigned       WIDTH   = 3,
  parameter logic [WIDTH-1:0]  POLY    = 'b110,
  parameter logic [WIDTH-1:0]  SEED    = 'b001,
  parameter bit                ZERO_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_state
);

  localparam logic [WIDTH-1:0] SEED_EFF = WIDTH'(seed_fix(LFSR_MAX_W'(SEED), WIDTH));

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEED_EFF;
    end else if (i_load) begin
      r_state <= SEED_EFF;
    end else if (i_advance) begin
      r_state <= WIDTH'(lfsr_next(LFSR_MAX_W'(r_state), LFSR_MAX_W'(POLY), WIDTH, ZERO_EN));
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/bist_tpg.sv
// BIST stimulus controller: pulses cut_reset, then streams PATTERN_COUNT LFSR vectors on valid/ready.
// Define TPG_ZERO_PATTERN_EN to also apply the all-zero vector (de Bruijn sequence, period 2^WIDTH).
module bist_tpg
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH         = 3,
  parameter int unsigned      PATTERN_COUNT = 65,
  parameter logic [WIDTH-1:0] POLY          = 'b110,
  parameter logic [WIDTH-1:0] SEED          = 'b001,
  parameter int unsigned      RST_CYCLES    = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   pat_ready,
  output logic                                   pat_valid,
  output logic [WIDTH-1:0]                       pattern,
  output logic [$clog2(PATTERN_COUNT+1)-1:0]     pat_index,
  output logic                                   cut_reset,
  output logic                                   busy,
  output logic                                   done
);

  localparam int unsigned IDX_W = $clog2(PATTERN_COUNT + 1);
  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_COUNT - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
`ifdef TPG_ZERO_PATTERN_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  state_t           r_state;
  logic [RST_W-1:0] r_rst_cnt;
  logic [IDX_W-1:0] r_pat_index;
  logic             r_pat_valid;
  logic             r_cut_reset;
  logic             r_busy;
  logic             r_done;

  logic w_start_ok;
  logic w_xfer;
  logic w_last;
  logic w_load;
  logic w_advance;

  assign w_start_ok = start & ~abort & ((r_state == IDLE) | (r_state == DONE));
  assign w_xfer     = (r_state == RUN) & r_pat_valid & pat_ready;
  assign w_last     = (r_pat_index == IDX_LAST);
  // Final transfer does not advance, so DONE keeps showing the last applied vector
  assign w_load     = abort | (r_state == CUT_RST) | w_start_ok;
  assign w_advance  = w_xfer & ~w_last & ~abort;

  bist_lfsr #(
    .WIDTH   (WIDTH),
    .POLY    (POLY),
    .SEED    (SEED),
    .ZERO_EN (ZERO_EN)
  ) u_lfsr (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_advance (w_advance),
    .o_state   (pattern)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rst_cnt   <= '0;
      r_pat_index <= '0;
      r_pat_valid <= 1'b0;
      r_cut_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_rst_cnt   <= '0;
      r_pat_index <= '0;
      r_pat_valid <= 1'b0;
      r_cut_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= CUT_RST;
            r_rst_cnt   <= '0;
            r_pat_index <= '0;
            r_cut_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        CUT_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            r_state     <= RUN;
            r_cut_reset <= 1'b0;
            r_pat_valid <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + RST_W'(1);
          end
        end
        RUN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state     <= DONE;
              r_pat_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_pat_index <= r_pat_index + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pat_valid = r_pat_valid;
  assign pat_index = r_pat_index;
  assign cut_reset = r_cut_reset;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_bist_tpg.sv
// Directed bench for bist_tpg: default run, stall, abort, and a SEED=0/RST_CYCLES=3/PATTERN_COUNT=1 instance.
module tb_bist_tpg;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       pat_ready;
  logic       pat_valid;
  logic [2:0] pattern;
  logic [6:0] pat_index;
  logic       cut_reset;
  logic       busy;
  logic       done;

  logic       reset_n2;
  logic       start2;
  logic       abort2;
  logic       pat_ready2;
  logic       pat_valid2;
  logic [2:0] pattern2;
  logic [0:0] pat_index2;
  logic       cut_reset2;
  logic       busy2;
  logic       done2;

  int checks = 0;
  int errors = 0;

  logic [2:0] seq [8];
`ifdef TPG_ZERO_PATTERN_EN
  localparam int PERIOD = 8;
`else
  localparam int PERIOD = 7;
`endif

  bist_tpg u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .pat_ready (pat_ready),
    .pat_valid (pat_valid),
    .pattern   (pattern),
    .pat_index (pat_index),
    .cut_reset (cut_reset),
    .busy      (busy),
    .done      (done)
  );

  bist_tpg #(
    .PATTERN_COUNT (1),
    .SEED          (3'b000),
    .RST_CYCLES    (3)
  ) u_dut2 (
    .clk       (clk),
    .reset_n   (reset_n2),
    .start     (start2),
    .abort     (abort2),
    .pat_ready (pat_ready2),
    .pat_valid (pat_valid2),
    .pattern   (pattern2),
    .pat_index (pat_index2),
    .cut_reset (cut_reset2),
    .busy      (busy2),
    .done      (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pattern"}, 32'(pattern), 32'h1);
    chk({tag, "_index"}, 32'(pat_index), 32'h0);
    chk({tag, "_valid"}, 32'(pat_valid), 32'h0);
    chk({tag, "_cut_reset"}, 32'(cut_reset), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b101; seq[3] = 3'b011;
    seq[4] = 3'b111; seq[5] = 3'b110; seq[6] = 3'b100;
`ifdef TPG_ZERO_PATTERN_EN
    seq[7] = 3'b000;
`else
    seq[7] = 3'b001;
`endif
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; pat_ready = 1'b0;
    reset_n2 = 1'b0; start2 = 1'b0; abort2 = 1'b0; pat_ready2 = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset2_pattern", 32'(pattern2), 32'h1);
    chk("reset2_valid", 32'(pat_valid2), 32'h0);
    reset_n = 1'b1;
    reset_n2 = 1'b1;
    tick();
    chk_idle("idle");

    // Full default run with ready always high
    pat_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_cut_reset", 32'(cut_reset), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_valid_in_rst", 32'(pat_valid), 32'h0);
    tick();
    chk("t1_cut_reset_off", 32'(cut_reset), 32'h0);
    for (int k = 0; k < 65; k++) begin
      chk("t1_valid", 32'(pat_valid), 32'h1);
      chk("t1_pattern", 32'(pattern), 32'(seq[k % PERIOD]));
      chk("t1_index", 32'(pat_index), 32'(k));
      tick();
    end
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_valid_off", 32'(pat_valid), 32'h0);
    chk("t1_busy_off", 32'(busy), 32'h0);
    chk("t1_hold_pattern", 32'(pattern), 32'(seq[64 % PERIOD]));
    chk("t1_hold_index", 32'(pat_index), 32'd64);
    tick();
    chk("t1_done_held", 32'(done), 32'h1);

    // Rerun from DONE, stall at index 3
    pat_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_cut_reset", 32'(cut_reset), 32'h1);
    chk("t2_done_clr", 32'(done), 32'h0);
    pat_ready = 1'b1;
    tick();
    chk("t2_first", 32'(pattern), 32'h1);
    tick(); tick(); tick();
    chk("t2_idx3", 32'(pat_index), 32'd3);
    pat_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_stall_pattern", 32'(pattern), 32'h3);
      chk("t2_stall_index", 32'(pat_index), 32'd3);
      chk("t2_stall_valid", 32'(pat_valid), 32'h1);
    end
    pat_ready = 1'b1;
    tick();
    chk("t2_resume_pattern", 32'(pattern), 32'h7);
    chk("t2_resume_index", 32'(pat_index), 32'd4);

    // Abort at index 20, coincident with start
    for (int k = 0; k < 16; k++) tick();
    chk("t3_idx20", 32'(pat_index), 32'd20);
    chk("t3_pat20", 32'(pattern), 32'(seq[20 % PERIOD]));
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk_idle("t3_abort");
    tick();
    tick();
    chk_idle("t3_stay");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t3_replay_pattern", 32'(pattern), 32'h1);
    chk("t3_replay_index", 32'(pat_index), 32'd0);
    chk("t3_replay_valid", 32'(pat_valid), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_start_ignored_busy", 32'(busy), 32'h1);
    chk("t3_start_ignored_cut", 32'(cut_reset), 32'h0);
    chk("t3_start_ignored_idx", 32'(pat_index), 32'd1);
    chk("t3_start_ignored_pat", 32'(pattern), 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("t3_abort2");

    // Second instance: zero seed, three reset cycles, single pattern
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_cut_reset", 32'(cut_reset2), 32'h1);
      chk("t5_valid_low", 32'(pat_valid2), 32'h0);
      tick();
    end
    chk("t5_cut_reset_off", 32'(cut_reset2), 32'h0);
    chk("t5_valid", 32'(pat_valid2), 32'h1);
    chk("t5_pattern", 32'(pattern2), 32'h1);
    tick();
    chk("t5_hold_valid", 32'(pat_valid2), 32'h1);
    #2;
    reset_n2 = 1'b0;
    #1;
    chk("t5_async_valid", 32'(pat_valid2), 32'h0);
    chk("t5_async_busy", 32'(busy2), 32'h0);
    chk("t5_async_pattern", 32'(pattern2), 32'h1);
    reset_n2 = 1'b1;
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick(); tick(); tick();
    chk("t6_valid", 32'(pat_valid2), 32'h1);
    chk("t6_index", 32'(pat_index2), 32'h0);
    pat_ready2 = 1'b1;
    tick();
    pat_ready2 = 1'b0;
    chk("t6_done", 32'(done2), 32'h1);
    chk("t6_valid_off", 32'(pat_valid2), 32'h0);
    chk("t6_pattern", 32'(pattern2), 32'h1);
    chk("t6_index_hold", 32'(pat_index2), 32'h0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("t6_rerun_cut", 32'(cut_reset2), 32'h1);
    chk("t6_rerun_done", 32'(done2), 32'h0);
    tick(); tick(); tick();
    chk("t6_rerun_valid", 32'(pat_valid2), 32'h1);
    chk("t6_rerun_pattern", 32'(pattern2), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
